// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch unit: PC, req/ack memory handshake and 2-entry IF/ID FIFO.
// Optional FETCH_PERF_CNT_EN adds saturating stall_cycles/flush_count counters.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Freeze,
   input  logic        Branch_taken,
   input  logic [31:0] Branch_address,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC_out,
   output logic [31:0] instruction_out,
   output logic        valid_out
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] fifo_pc    [2];
   logic [31:0] fifo_instr [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;

   logic        pop;
   logic        push;
   logic [1:0]  next_count;
   logic        issue_ok;
   logic [31:0] addr_plus4;

   always_comb begin
      valid_out       = (count != 2'd0);
      PC_out          = valid_out ? fifo_pc[rd_ptr]    : 32'h0;
      instruction_out = valid_out ? fifo_instr[rd_ptr] : 32'h0;
      pop             = valid_out && !Freeze;
      push            = (state == REQ) && imem_ack;
      next_count      = count - {1'b0, pop} + {1'b0, push};
      // Once acked nothing is outstanding, so the next request only needs a free slot.
      issue_ok        = (next_count < 2'd2);
      addr_plus4      = imem_addr + 32'd4;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         count     <= 2'd0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
      end else if (Branch_taken) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         pc     <= Branch_address;
         case (state)
            IDLE: begin
               state     <= REQ;
               imem_req  <= 1'b1;
               imem_addr <= Branch_address;
            end
            REQ: begin
               // An un-acked request cannot be withdrawn; its response must be swallowed.
               if (imem_ack) imem_addr <= Branch_address;
               else          state     <= DROP;
            end
            default: ;
         endcase
      end else begin
         count <= next_count;
         if (pop)  rd_ptr <= ~rd_ptr;
         if (push) wr_ptr <= ~wr_ptr;
         case (state)
            IDLE: begin
               if (issue_ok) begin
                  state     <= REQ;
                  imem_req  <= 1'b1;
                  imem_addr <= pc;
               end
            end
            REQ: begin
               if (imem_ack) begin
                  pc <= addr_plus4;
                  if (issue_ok) begin
                     imem_addr <= addr_plus4;
                  end else begin
                     state    <= IDLE;
                     imem_req <= 1'b0;
                  end
               end
            end
            DROP: begin
               if (imem_ack) begin
                  state     <= REQ;
                  imem_addr <= pc;
               end
            end
            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !Branch_taken) begin
         fifo_pc[wr_ptr]    <= addr_plus4;
         fifo_instr[wr_ptr] <= imem_rdata;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles <= 32'h0;
         flush_count  <= 32'h0;
      end else begin
         if (!valid_out && !Freeze && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
         if (Branch_taken && flush_count != 32'hFFFF_FFFF)
            flush_count <= flush_count + 32'd1;
      end
   end
`endif

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Fetch-side producer for the IF/ID pipeline register. Owns the PC, issues requests to instruction memory over a req/ack handshake, and buffers returned instructions in a 2-entry FIFO.
- Presents {PC+4, instruction} to the IF/ID register, which samples it on any edge where Freeze=0.
- A taken branch from EX redirects the PC, flushes the FIFO and discards any in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  clock, rising-edge.
rst  in  1  asynchronous, active-low reset.
Freeze  in  1  hazard stall; the IF/ID register holds, and the FIFO head is not consumed.
Branch_taken  in  1  redirect pulse from EX.
Branch_address  in  32  redirect target.
imem_req  out  1  memory request.
imem_addr  out  32  request address, word-aligned.
imem_ack  in  1  one-cycle response strobe; rdata is valid with it.
imem_rdata  in  32  instruction word.
PC_out  out  32  fetch address + 4 of the FIFO head.
instruction_out  out  32  FIFO head instruction; 32'h0 when the FIFO is empty.
valid_out  out  1  FIFO non-empty.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=IDLE, FIFO count=0, imem_req=0, imem_addr=RESET_PC, PC_out=0, instruction_out=0, valid_out=0.
- FIFO: 2 entries of {addr+4, instr}.
  - Pop on an edge where valid_out=1 and Freeze=0.
  - Push on an edge where an accepted response arrives.
  - Push and pop on the same edge are both allowed; count is unchanged.
- Issue rule: a new request may start only when count + outstanding < 2, counted after this edge's pop. This guarantees an ack always has room.
- FSM states:
  - IDLE: imem_req=0. Go to REQ when the issue rule allows; imem_addr<=pc.
  - REQ: imem_req=1; imem_addr is stable until ack.
    - On ack: push {imem_addr+4, imem_rdata} and set pc<=imem_addr+4.
    - If the issue rule still allows, remain in REQ with imem_addr<=imem_addr+4, giving back-to-back requests. Otherwise go to IDLE.
  - DROP: imem_req=1 with the stale address. On ack, discard rdata, set imem_addr<=pc and go to REQ.
- Throughput: one instruction per ack. Minimum latency from req to valid_out is ack cycle + 1.
- Branch_taken=1 at an edge. It has priority over Freeze, ack and pop.
  - FIFO flushed; count=0, so valid_out=0 on the next cycle.
  - pc<=Branch_address.
  - From IDLE: go to REQ with imem_addr<=Branch_address.
  - From REQ without ack in the same cycle: go to DROP, because the in-flight request cannot be aborted.
  - From REQ with ack in the same cycle: the response is discarded; stay in REQ with imem_addr<=Branch_address.
  - From DROP: stay in DROP; only pc is updated.
- Freeze=1: no pop; outputs hold their values. Fetching continues until the FIFO is full, then the FSM parks in IDLE.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- Reset mid-transaction: imem_req drops immediately. The memory must tolerate an abandoned request.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds output ports stall_cycles[31:0] and flush_count[31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
  - stall_cycles increments each cycle with valid_out=0 and Freeze=0.
  - flush_count increments on each Branch_taken.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, zero-wait memory (ack in the cycle after req, rdata=addr): valid_out first rises 2 cycles after reset release.
  - Consecutive pops give PC_out 4, 8, 12… with instruction_out 0, 4, 8….
- Freeze held high 6 cycles with ack always available: at most 2 pushes, then imem_req=0.
  - Outputs hold; after release, sequence order is preserved with no loss or duplication.
- Branch_taken to 32'h100 while in REQ with ack delayed 3 cycles: the stale ack data is never visible.
  - The next valid_out shows PC_out=32'h104.
- Branch_taken coincident with ack and Freeze=1: the acked word is discarded, the FIFO is empty next cycle, and imem_addr=Branch_address.
- RESET_PC=32'hFFFF_FFF8: first two outputs have PC_out FFFF_FFFC then 0000_0000 (wrap).
- rst pulsed low while imem_req=1: imem_req falls immediately.
  - After release, the fetch restarts at RESET_PC and valid_out=0 until the first ack.
